// File: rtl/light_music_pkg.sv
// Shared definitions for the light-music display path: peak-dot states,
// counter-width helper and the default tick prescale.
package light_music_pkg;

  typedef enum logic [1:0] {
    PEAK_IDLE = 2'd0,
    PEAK_HOLD = 2'd1,
    PEAK_FALL = 2'd2
  } peak_state_e;

  localparam int DEFAULT_TICK_DIV = 65536;
  localparam int HEIGHT_W         = 5;

  // Bits needed to count 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vu_bar_meter_if.sv
// Level/strobe inputs and LED-bank outputs of the VU bar meter.
interface vu_bar_meter_if
  import light_music_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int LEVEL_W  = 8
);
  logic [LEVEL_W-1:0]  level;
  logic                data_ready;
  logic [NUM_LEDS-1:0] leds;
  logic [HEIGHT_W-1:0] peak_idx;
  logic [HEIGHT_W-1:0] bar_height;

  modport master (output level, data_ready, input leds, peak_idx, bar_height);
  modport slave  (input level, data_ready, output leds, peak_idx, bar_height);
endinterface

// File: rtl/strobe_sync.sv
// Three-flop synchroniser for a slow foreign-domain strobe, followed by a
// registered one-cycle pulse on each synchronised rising edge.
module strobe_sync (
  input  logic clk_pwm,
  input  logic nreset,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
    rise_d = (sync_q[2:1] == 2'b01);
  end

  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      sync_q <= 3'b000;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/vu_bar_meter.sv
// VU bar meter: level -> segment height, fast-attack/slow-decay bar and a
// peak-hold dot, all driven straight onto the LED bank in the clk_pwm domain.
module vu_bar_meter
  import light_music_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int LEVEL_W         = 8,
  parameter int STEP            = 7,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV,
  parameter int DECAY_TICKS     = 4,
  parameter int PEAK_HOLD_TICKS = 32
) (
  input  logic           clk_pwm,
  input  logic           nreset,
  vu_bar_meter_if.slave  bus
);

  localparam int PW = clog2(TICK_DIV);
  localparam int DW = clog2(DECAY_TICKS + 1);
  localparam int HW = clog2(PEAK_HOLD_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_TICKS - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(PEAK_HOLD_TICKS);

  logic                rp;
  logic                cap_q, cap_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DW-1:0]       decay_cnt_q, decay_cnt_d;
  logic [HEIGHT_W-1:0] target_q, target_d;
  logic [HEIGHT_W-1:0] bar_q, bar_d;
  logic [HEIGHT_W-1:0] peak_q, peak_d;
  logic [HEIGHT_W-1:0] peak_dec;
  logic [HW-1:0]       hold_q, hold_d;
  peak_state_e         state_q, state_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [HEIGHT_W-1:0] h;
  logic [5:0]          lvl6;
  logic                tick;
  logic                decay_evt;
  logic                unused_level;

  strobe_sync u_sync (
    .clk_pwm  (clk_pwm),
    .nreset   (nreset),
    .async_in (bus.data_ready),
    .rise     (rp)
  );

  // The PWM stage only ever produces 6 significant level bits; the rest are
  // deliberately dropped rather than trusted to be zero.
  assign lvl6         = bus.level[5:0];
  assign unused_level = ^bus.level;

  always_comb begin
    h = '0;
    for (int k = 1; k <= NUM_LEDS; k++) begin
      if (int'(lvl6) >= k * STEP) h = h + HEIGHT_W'(1);
    end
  end

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    decay_evt = tick && (decay_cnt_q == DECAY_LAST);
    decay_cnt_d = decay_cnt_q;
    if (tick) decay_cnt_d = decay_evt ? '0 : decay_cnt_q + DW'(1);
  end

  // Capture is one cycle after the rise pulse so the level has already
  // been refreshed by the PWM stage; attack beats a coincident decay step.
  always_comb begin
    cap_d    = rp;
    target_d = cap_q ? h : target_q;
    bar_d    = bar_q;
    if (cap_q && (h > bar_q))                   bar_d = h;
    else if (decay_evt && (bar_q > target_d))   bar_d = bar_q - HEIGHT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    peak_d   = peak_q;
    hold_d   = hold_q;
    peak_dec = (peak_q == '0) ? '0 : peak_q - HEIGHT_W'(1);
    if (bar_q > peak_q) begin
      peak_d  = bar_q;
      hold_d  = HOLD_INIT;
      state_d = PEAK_HOLD;
    end else if (tick) begin
      unique case (state_q)
        PEAK_IDLE: state_d = PEAK_IDLE;
        PEAK_HOLD: begin
          if (hold_q == HW'(1)) state_d = PEAK_FALL;
          else                  hold_d  = hold_q - HW'(1);
        end
        PEAK_FALL: begin
          peak_d = (bar_q > peak_dec) ? bar_q : peak_dec;
          if (peak_d == '0) state_d = PEAK_IDLE;
        end
        default: state_d = PEAK_IDLE;
      endcase
    end
  end

  always_comb begin
    leds_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = (HEIGHT_W'(i) < bar_d) ||
                  ((peak_d != '0) && (HEIGHT_W'(i) == peak_d - HEIGHT_W'(1)));
    end
  end

  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      cap_q       <= 1'b0;
      presc_q     <= '0;
      decay_cnt_q <= '0;
      target_q    <= '0;
      bar_q       <= '0;
      peak_q      <= '0;
      hold_q      <= '0;
      state_q     <= PEAK_IDLE;
      leds_q      <= '0;
    end else begin
      cap_q       <= cap_d;
      presc_q     <= presc_d;
      decay_cnt_q <= decay_cnt_d;
      target_q    <= target_d;
      bar_q       <= bar_d;
      peak_q      <= peak_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
      leds_q      <= leds_d;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.peak_idx   = peak_q;
  assign bus.bar_height = bar_q;

endmodule

// File: tb/tb_vu_bar_meter.sv
// Self-checking bench for vu_bar_meter: a per-edge reference model built from
// the meter's rules compared against the DUT every cycle, plus pinned literals.
module tb_vu_bar_meter;

  localparam int NUM_LEDS        = 8;
  localparam int LEVEL_W         = 8;
  localparam int STEP            = 7;
  localparam int TICK_DIV        = 4;
  localparam int DECAY_TICKS     = 2;
  localparam int PEAK_HOLD_TICKS = 3;

  logic clk_pwm = 1'b0;
  logic nreset  = 1'b1;

  int tests = 0;
  int fails = 0;

  vu_bar_meter_if #(.NUM_LEDS(NUM_LEDS), .LEVEL_W(LEVEL_W)) bus ();

  vu_bar_meter #(
    .NUM_LEDS        (NUM_LEDS),
    .LEVEL_W         (LEVEL_W),
    .STEP            (STEP),
    .TICK_DIV        (TICK_DIV),
    .DECAY_TICKS     (DECAY_TICKS),
    .PEAK_HOLD_TICKS (PEAK_HOLD_TICKS)
  ) dut (
    .clk_pwm (clk_pwm),
    .nreset  (nreset),
    .bus     (bus)
  );

  always #5 clk_pwm = ~clk_pwm;

  // Reference model state: edges since reset, strobe history, bar/peak.
  int m_edge  = 0;
  int m_bar   = 0;
  int m_tgt   = 0;
  int m_peak  = 0;
  int m_since = 0;
  int m_hist [6] = '{default: 0};
  int s_level, s_h, s_old_bar;
  bit s_cap, s_tick, s_decay;

  function automatic int hmodel(input int l);
    int v;
    v = (l & 63) / STEP;
    return (v > NUM_LEDS) ? NUM_LEDS : v;
  endfunction

  function automatic int ledsmodel(input int b, input int p);
    int r;
    r = 0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (i < b || (p != 0 && i == p - 1)) r = r | (1 << i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    tests++;
    if (actual !== 32'(expected)) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on every edge, then the DUT outputs are compared 1 ns later.
  always @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      m_edge = 0; m_bar = 0; m_tgt = 0; m_peak = 0; m_since = 0;
      for (int i = 0; i < 6; i++) m_hist[i] = 0;
    end else begin
      for (int i = 5; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'(bus.data_ready);
      s_level   = int'(bus.level);
      m_edge++;
      s_cap     = (m_hist[4] == 1) && (m_hist[5] == 0);
      s_tick    = (m_edge % TICK_DIV) == 0;
      s_decay   = (m_edge % (TICK_DIV * DECAY_TICKS)) == 0;
      s_h       = hmodel(s_level);
      s_old_bar = m_bar;
      if (s_cap) m_tgt = s_h;
      if (s_cap && s_h > m_bar)             m_bar = s_h;
      else if (s_decay && m_bar > m_tgt)    m_bar = m_bar - 1;
      if (s_old_bar > m_peak) begin
        m_peak  = s_old_bar;
        m_since = 0;
      end else if (s_tick && m_peak > 0) begin
        if (m_since >= PEAK_HOLD_TICKS)
          m_peak = (s_old_bar > m_peak - 1) ? s_old_bar : m_peak - 1;
        else
          m_since++;
      end
    end
    #1;
    checkOutput("leds",       32'(bus.leds),       ledsmodel(m_bar, m_peak));
    checkOutput("peak_idx",   32'(bus.peak_idx),   m_peak);
    checkOutput("bar_height", 32'(bus.bar_height), m_bar);
  end

  task automatic applyStimulus(input int lvl, input int hi, input int lo);
    @(negedge clk_pwm);
    bus.level      = LEVEL_W'(lvl);
    bus.data_ready = 1'b1;
    repeat (hi) @(negedge clk_pwm);
    bus.data_ready = 1'b0;
    repeat (lo) @(negedge clk_pwm);
  endtask

  initial begin
    bus.level      = '0;
    bus.data_ready = 1'b0;
    #1 nreset = 1'b0;

    checkOutput("h_0",   32'(hmodel(0)),   0);
    checkOutput("h_6",   32'(hmodel(6)),   0);
    checkOutput("h_7",   32'(hmodel(7)),   1);
    checkOutput("h_55",  32'(hmodel(55)),  7);
    checkOutput("h_56",  32'(hmodel(56)),  8);
    checkOutput("h_63",  32'(hmodel(63)),  8);
    checkOutput("h_D5",  32'(hmodel(8'hD5)), 3);
    checkOutput("leds_b3p6", 32'(ledsmodel(3, 6)), 8'h27);

    repeat (3) @(negedge clk_pwm);
    nreset = 1'b1;

    // Idle after reset
    repeat (100) @(negedge clk_pwm);
    checkOutput("t1_bar",  32'(bus.bar_height), 0);
    checkOutput("t1_peak", 32'(bus.peak_idx),   0);
    checkOutput("t1_leds", 32'(bus.leds),       0);

    // Full-scale attack latency
    bus.level      = 8'd63;
    bus.data_ready = 1'b1;
    repeat (4) @(posedge clk_pwm);
    #2 checkOutput("t2_bar_early", 32'(bus.bar_height), 0);
    @(posedge clk_pwm);
    #2 checkOutput("t2_bar", 32'(bus.bar_height), 8);
    checkOutput("t2_leds", 32'(bus.leds), 8'hFF);
    @(negedge clk_pwm);
    bus.data_ready = 1'b0;
    repeat (5) @(negedge clk_pwm);

    // Decay to zero with peak hold/fall
    applyStimulus(0, 2, 120);
    checkOutput("t3_bar",  32'(bus.bar_height), 0);
    checkOutput("t3_peak", 32'(bus.peak_idx),   0);

    // Decay stops at target
    applyStimulus(21, 2, 20);
    checkOutput("t4_bar3", 32'(bus.bar_height), 3);
    applyStimulus(20, 2, 30);
    checkOutput("t4_bar2", 32'(bus.bar_height), 2);

    // Attack coinciding with a decay step
    applyStimulus(35, 2, 12);
    applyStimulus(0, 2, 6);
    while ((m_edge % (TICK_DIV * DECAY_TICKS)) != 3) @(negedge clk_pwm);
    bus.level      = 8'd49;
    bus.data_ready = 1'b1;
    repeat (5) @(posedge clk_pwm);
    #2 checkOutput("t5_bar", 32'(bus.bar_height), 7);
    @(posedge clk_pwm);
    #2 checkOutput("t5_peak", 32'(bus.peak_idx), 7);
    @(negedge clk_pwm);
    bus.data_ready = 1'b0;
    repeat (4) @(negedge clk_pwm);

    // Reset while the peak is falling, strobe held high across release
    applyStimulus(0, 2, 25);
    bus.level      = 8'd63;
    bus.data_ready = 1'b1;
    nreset         = 1'b0;
    #2;
    checkOutput("t6_bar_rst",  32'(bus.bar_height), 0);
    checkOutput("t6_peak_rst", 32'(bus.peak_idx),   0);
    checkOutput("t6_leds_rst", 32'(bus.leds),       0);
    repeat (3) @(negedge clk_pwm);
    nreset = 1'b1;
    repeat (5) @(posedge clk_pwm);
    #2 checkOutput("t6_bar", 32'(bus.bar_height), 8);
    @(negedge clk_pwm);
    bus.level = 8'd0;
    repeat (40) @(negedge clk_pwm);
    checkOutput("t6_single_cap", 32'(bus.bar_height), 8);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk_pwm);

    // Randomised strobes and levels, upper level bits included
    for (int n = 0; n < 60; n++)
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(1, 10)),
                    int'($urandom_range(2, 40)));

    repeat (5) @(negedge clk_pwm);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
